team_06_i2s_rx: RTL and testbench
=================================

Name: team_06_i2s_rx

Overview:
- Master-mode I2S receiver; the input-side counterpart of the team's i2s-to-DAC serializer.
- Generates bclk and ws (word select) for an external I2S ADC or microphone, and deserializes its serial_in line MSB-first.
- Presents each channel's sample as a parallel word with a valid/ready handshake to the downstream audio datapath.

Parameters:
- DATA_W, 8, sample bits kept per channel (MSB-aligned); must be less than SLOT_W.
- SLOT_W, 16, bclk periods per channel slot.
- CLK_DIV, 4, clk cycles per bclk half-period (bclk = clk / (2*CLK_DIV)); must be at least 2.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- en  input  1  run enable; low = synchronous idle
- serial_in  input  1  I2S SD from the ADC
- bclk  output  1  bit clock to the ADC
- ws  output  1  word select; 0 = left, 1 = right
- parallel_out  output  DATA_W  captured sample, MSB first on the wire
- sample_right  output  1  channel of parallel_out (1 = right)
- sample_valid  output  1  parallel_out holds an unconsumed sample
- sample_ready  input  1  consumer accepts when valid and ready are both high
- overrun  output  1  sticky: a sample was overwritten before acceptance

Behaviour:
- Reset values: bclk=0, ws=0, parallel_out=0, sample_right=0, sample_valid=0, overrun=0. All internal counters and the shift register are 0.
- Divider: div_cnt counts 0..CLK_DIV-1 while en=1. At terminal count, bclk toggles and div_cnt returns to 0.
- Rise event: the clk edge where bclk goes 0->1. Fall event: the clk edge where bclk goes 1->0.
- Bit counter: bit_cnt counts 0..2*SLOT_W-1 and increments on every fall event, wrapping to 0.
- ws is registered: equal to (bit_cnt >= SLOT_W), updated at the fall event. ws is therefore low for SLOT_W bclk periods, then high for SLOT_W.
- I2S one-bit delay: at a rise event, slot position p = (bit_cnt - 1) mod 2*SLOT_W.
  - Channel = (p >= SLOT_W); bit index k = p mod SLOT_W.
  - If k < DATA_W, serial_in is shifted into the shift register at that edge.
  - Bits with k >= DATA_W are ignored (truncation).
- Sample completion happens at the rise event with k = DATA_W-1. At that same edge:
  - parallel_out <= {shift[DATA_W-2:0], serial_in}
  - sample_right <= channel
  - sample_valid <= 1
- Output is visible the clk cycle bclk goes high.
- Handshake:
  - sample_valid clears on an edge with valid & ready, unless a completion occurs on that same edge. In that case the new sample loads, valid stays 1 and no overrun is raised.
  - A completion while valid=1 and ready=0 overwrites the output and sets overrun=1.
  - overrun clears only on rst or while en=0.
- First frame after reset or enable: bit_cnt starts at 0. The first rise has p = 2*SLOT_W-1 (k >= DATA_W), so it is ignored; no partial sample is produced.
- en=0 acts synchronously at the next edge:
  - bclk=0, ws=0, counters and shift register to 0, overrun=0.
  - parallel_out, sample_right and sample_valid are retained; handshake acceptance still clears valid.
  - Re-enabling restarts at bit_cnt 0.
- rst mid-frame: all state returns to reset values immediately; the partial sample is discarded.
- Timing at defaults: frame = 2*16*8 = 256 clk; one sample completes every 128 clk.

Optional Feature:
- Macro: I2S_RX_LEFT_ONLY_EN.
- Defined: only left-slot samples complete. Right-slot bits are not shifted, sample_right is always 0, and one sample is delivered per frame (256 clk at defaults).
- Undefined: both channels are delivered, alternating left then right.

Decomposition:
- Package team_06_i2s_pkg holds:
  - default constants I2S_DATA_W=8, I2S_SLOT_W=16, I2S_CLK_DIV=4
  - typedef enum logic {I2S_LEFT=1'b0, I2S_RIGHT=1'b1} i2s_ch_e
- Optional shared sub-module: team_06_i2s_clkgen (divider, bclk, ws, bit_cnt, rise/fall strobes), reusable by the DAC transmitter.
- Shifting and handshake logic stay in team_06_i2s_rx.

Test Plan:
- Reset: rst=1 for 40 ns (clk period 20 ns) -> all outputs 0, bclk flat. After release, first bclk rise at 80 ns and ws first high after 16 fall events.
- Left capture: the ADC model drives 0xDB on left-slot bits 0..7 (bits 8..15 = 1), changing on bclk fall -> parallel_out=0xDB, sample_right=0, valid=1, on the 9th rise after ws falls.
- Stereo: left 0x99, right 0xF9 with sample_ready tied high -> valid pulses twice per 256 clk, outputs 0x99 then 0xF9, sample_right 0 then 1, overrun stays 0.
- Overrun: sample_ready=0 across two completions -> parallel_out holds the second sample, overrun=1. Then en=0 -> overrun=0, data and valid retained.
- Simultaneous: ready asserted exactly on a completion edge -> new sample loads, valid stays 1, overrun stays 0.
- Mid-frame rst/en: rst=1 for 1000 ns mid-left-slot -> no sample emitted for the interrupted slot; the next valid sample comes from the first complete left slot after release.

Source files
------------

// File: rtl/team_06_i2s_pkg.sv
// rtl/team_06_i2s_pkg.sv - shared constants and channel type for the team_06 I2S blocks
package team_06_i2s_pkg;

  localparam int I2S_DATA_W  = 8;
  localparam int I2S_SLOT_W  = 16;
  localparam int I2S_CLK_DIV = 4;

  typedef enum logic {I2S_LEFT = 1'b0, I2S_RIGHT = 1'b1} i2s_ch_e;

endpackage

// File: rtl/team_06_i2s_clkgen.sv
// rtl/team_06_i2s_clkgen.sv - I2S master timing: bclk divider, slot bit counter, ws and rise strobe
module team_06_i2s_clkgen
  import team_06_i2s_pkg::*;
#(
  parameter int SLOT_W  = I2S_SLOT_W,
  parameter int CLK_DIV = I2S_CLK_DIV,
  localparam int DIV_W  = $clog2(CLK_DIV),
  localparam int BIT_W  = $clog2(2 * SLOT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             bclk,
  output logic             ws,
  output logic [BIT_W-1:0] bit_cnt,
  output logic             rise
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
  localparam logic [BIT_W-1:0] SLOT_L   = BIT_W'(SLOT_W);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             bclk_q, bclk_d;
  logic             ws_q, ws_d;
  logic             tick;

  always_comb begin
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    bclk_d    = bclk_q;
    ws_d      = ws_q;
    tick      = en && (div_cnt_q == DIV_LAST);
    rise      = tick && !bclk_q;
    if (!en) begin
      div_cnt_d = '0;
      bit_cnt_d = '0;
      bclk_d    = 1'b0;
      ws_d      = 1'b0;
    end else if (tick) begin
      div_cnt_d = '0;
      bclk_d    = !bclk_q;
      if (bclk_q) begin
        // ws follows the post-increment count so it changes one bit ahead of the slot data
        bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);
        ws_d      = (bit_cnt_d >= SLOT_L);
      end
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      bclk_q    <= 1'b0;
      ws_q      <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      bclk_q    <= bclk_d;
      ws_q      <= ws_d;
    end
  end

  assign bclk    = bclk_q;
  assign ws      = ws_q;
  assign bit_cnt = bit_cnt_q;

endmodule

// File: rtl/team_06_i2s_rx.sv
// rtl/team_06_i2s_rx.sv - master-mode I2S receiver with valid/ready sample output
// Define I2S_RX_LEFT_ONLY_EN to capture only the left slot of each frame.
module team_06_i2s_rx
  import team_06_i2s_pkg::*;
#(
  parameter int DATA_W  = I2S_DATA_W,
  parameter int SLOT_W  = I2S_SLOT_W,
  parameter int CLK_DIV = I2S_CLK_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              serial_in,
  output logic              bclk,
  output logic              ws,
  output logic [DATA_W-1:0] parallel_out,
  output logic              sample_right,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun
);

  localparam int BIT_W = $clog2(2 * SLOT_W);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
  localparam logic [BIT_W-1:0] SLOT_L   = BIT_W'(SLOT_W);
  localparam logic [BIT_W-1:0] DATA_L   = BIT_W'(DATA_W);
  localparam logic [BIT_W-1:0] LAST_K   = BIT_W'(DATA_W - 1);

  logic             rise;
  logic [BIT_W-1:0] bit_cnt;
  logic [BIT_W-1:0] pos;
  logic [BIT_W-1:0] k;
  i2s_ch_e          ch;
  logic             take;
  logic             complete;

  logic [DATA_W-1:0] shift_in;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] par_q, par_d;
  i2s_ch_e           right_q, right_d;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;

  team_06_i2s_clkgen #(
    .SLOT_W  (SLOT_W),
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .bclk    (bclk),
    .ws      (ws),
    .bit_cnt (bit_cnt),
    .rise    (rise)
  );

  always_comb begin
    // The ADC lags ws by one bclk, so the bit on the wire belongs to the previous count
    pos      = (bit_cnt == '0) ? BIT_LAST : bit_cnt - BIT_W'(1);
    ch       = (pos >= SLOT_L) ? I2S_RIGHT : I2S_LEFT;
    k        = (ch == I2S_RIGHT) ? pos - SLOT_L : pos;
`ifdef I2S_RX_LEFT_ONLY_EN
    take     = rise && (k < DATA_L) && (ch == I2S_LEFT);
`else
    take     = rise && (k < DATA_L);
`endif
    complete = take && (k == LAST_K);
    shift_in = {shift_q[DATA_W-2:0], serial_in};

    shift_d  = shift_q;
    par_d    = par_q;
    right_d  = right_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;

    if (!en) begin
      shift_d = '0;
      ovr_d   = 1'b0;
    end else if (take) begin
      shift_d = shift_in;
    end

    if (complete) begin
      par_d   = shift_in;
      right_d = ch;
      valid_d = 1'b1;
      if (valid_q && !sample_ready) begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      par_q   <= '0;
      right_q <= I2S_LEFT;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      par_q   <= par_d;
      right_q <= right_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign parallel_out = par_q;
  assign sample_right = right_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_team_06_i2s_rx.sv
// tb/tb_team_06_i2s_rx.sv - randomized bench for team_06_i2s_rx with a frame-level ADC/consumer model
`timescale 1ns/1ps
module tb_team_06_i2s_rx;

  localparam int DATA_W  = 8;
  localparam int SLOT_W  = 16;
  localparam int CLK_DIV = 4;
`ifdef I2S_RX_LEFT_ONLY_EN
  localparam bit LEFT_ONLY = 1'b1;
`else
  localparam bit LEFT_ONLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic en = 1'b0;
  logic serial_in = 1'b0;
  logic sample_ready = 1'b0;
  logic bclk, ws, sample_right, sample_valid, overrun;
  logic [DATA_W-1:0] parallel_out;

  int n_checks = 0;
  int n_errors = 0;

  // Frame-level model state, owned by the monitor below
  int                falls = 0;
  int                cur_p = -1;
  int                n_comp = 0;
  logic              bclk_prev = 1'b0;
  logic              en_p = 1'b0;
  logic              ready_p = 1'b0;
  logic              comp_next = 1'b0;
  logic [SLOT_W-1:0] word_l = '0;
  logic [SLOT_W-1:0] word_r = '0;
  logic              m_valid = 1'b0;
  logic              m_right = 1'b0;
  logic              m_ovr = 1'b0;
  logic [DATA_W-1:0] m_data = '0;

  // Stimulus-owned word selection
  logic              fixed_words = 1'b0;
  logic [SLOT_W-1:0] fix_l = '0;
  logic [SLOT_W-1:0] fix_r = '0;

  team_06_i2s_rx #(
    .DATA_W  (DATA_W),
    .SLOT_W  (SLOT_W),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .serial_in    (serial_in),
    .bclk         (bclk),
    .ws           (ws),
    .parallel_out (parallel_out),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun)
  );

  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ADC drives on bclk falls; consumer/overrun rules applied per clk edge
  always @(negedge clk) begin
    logic acc, rise_e, fall_e, ch;
    int   p, k;
    acc    = m_valid && ready_p;
    rise_e = bclk && !bclk_prev;
    fall_e = !bclk && bclk_prev;
    if (rst) begin
      falls = 0; cur_p = -1; comp_next = 1'b0;
      m_valid = 1'b0; m_right = 1'b0; m_ovr = 1'b0; m_data = '0;
    end else if (!en_p) begin
      falls = 0; cur_p = -1; comp_next = 1'b0; m_ovr = 1'b0;
      if (acc) m_valid = 1'b0;
    end else begin
      if (rise_e) begin
        p  = (falls + 2 * SLOT_W - 1) % (2 * SLOT_W);
        k  = p % SLOT_W;
        ch = (p >= SLOT_W);
        if (k == DATA_W - 1 && (!LEFT_ONLY || !ch)) begin
          if (m_valid && !acc) m_ovr = 1'b1;
          m_valid = 1'b1;
          m_right = ch;
          m_data  = ch ? word_r[SLOT_W-1 -: DATA_W] : word_l[SLOT_W-1 -: DATA_W];
          n_comp++;
        end else if (acc) begin
          m_valid = 1'b0;
        end
        comp_next = 1'b0;
      end else if (acc) begin
        m_valid = 1'b0;
      end
      if (fall_e) begin
        falls++;
        check_eq("ws", ws, ((falls % (2 * SLOT_W)) >= SLOT_W));
        p = (falls - 1) % (2 * SLOT_W);
        cur_p = p;
        if (p == 0) begin
          word_l = fixed_words ? fix_l : SLOT_W'($urandom);
          word_r = fixed_words ? fix_r : SLOT_W'($urandom);
        end
        k  = p % SLOT_W;
        ch = (p >= SLOT_W);
        serial_in = ch ? word_r[SLOT_W-1-k] : word_l[SLOT_W-1-k];
        comp_next = (k == DATA_W - 1) && (!LEFT_ONLY || !ch);
      end
    end
    if (!rst && (rise_e || acc)) begin
      check_eq("valid", sample_valid, m_valid);
      check_eq("overrun", overrun, m_ovr);
      if (m_valid) begin
        check_eq("data", parallel_out, m_data);
        check_eq("right", sample_right, m_right);
      end
    end
    bclk_prev = bclk;
    en_p      = en;
    ready_p   = sample_ready;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_comp(input string tag, input int n, input int budget);
    int start = n_comp;
    int t = 0;
    while (n_comp - start < n && t < budget) begin
      step(1);
      t++;
    end
    check_eq(tag, n_comp - start, n);
  endtask

  initial begin
    int cnt;
    int c0;
    logic [DATA_W-1:0] held;

    rst = 1'b0;
    #1 rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check_eq("rst_bclk", bclk, 0);
    check_eq("rst_ws", ws, 0);
    check_eq("rst_data", parallel_out, 0);
    check_eq("rst_right", sample_right, 0);
    check_eq("rst_valid", sample_valid, 0);
    check_eq("rst_overrun", overrun, 0);
    #1 rst = 1'b0; en = 1'b1;

    cnt = 0;
    do begin
      @(posedge clk); #1; cnt++;
    end while (!bclk && cnt < 20);
    check_eq("first_rise_edges", cnt, CLK_DIV);

    // Left capture with held output
    fixed_words = 1'b1; fix_l = 16'hDBFF; fix_r = 16'h5A3C;
    sample_ready = 1'b0;
    wait_comp("left_comp", 1, 600);
    check_eq("left_data", parallel_out, 8'hDB);
    check_eq("left_right", sample_right, 0);
    check_eq("left_valid", sample_valid, 1);
    check_eq("left_ws", ws, 0);
    sample_ready = 1'b1;
    step(2);

    // Stereo with ready tied high
    fix_l = 16'h99A5; fix_r = 16'hF93C;
    step(600);
    cnt = 0;
    for (int i = 0; i < 2 * SLOT_W * 2 * CLK_DIV; i++) begin
      step(1);
      if (sample_valid) cnt++;
    end
    check_eq("valid_per_frame", cnt, LEFT_ONLY ? 1 : 2);
    check_eq("stereo_overrun", overrun, 0);

    // Random words and random back-pressure
    fixed_words = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      sample_ready = 1'($urandom_range(0, 1));
      step(1);
    end

    // Overrun, then disable clears it but keeps the sample
    en = 1'b0; sample_ready = 1'b1;
    step(4);
    en = 1'b1; sample_ready = 1'b0;
    wait_comp("ovr_comps", 2, 900);
    step(1);
    check_eq("ovr_set", overrun, 1);
    check_eq("ovr_data", parallel_out, m_data);
    held = parallel_out;
    en = 1'b0;
    step(2);
    check_eq("dis_overrun", overrun, 0);
    check_eq("dis_valid", sample_valid, 1);
    check_eq("dis_data", parallel_out, held);
    check_eq("dis_bclk", bclk, 0);
    sample_ready = 1'b1;
    step(2);
    check_eq("dis_accept", sample_valid, 0);

    // Ready only on the completion edge itself
    sample_ready = 1'b0; en = 1'b1;
    wait_comp("sim_first", 1, 600);
    cnt = 0;
    while (!comp_next && cnt < 600) begin
      @(negedge clk); #1; cnt++;
    end
    check_eq("sim_found", (cnt < 600), 1);
    c0 = n_comp;
    step(3);
    sample_ready = 1'b1;
    step(1);
    sample_ready = 1'b0;
    @(negedge clk); #1;
    check_eq("sim_comp", n_comp - c0, 1);
    check_eq("sim_valid", sample_valid, 1);
    check_eq("sim_overrun", overrun, 0);
    check_eq("sim_data", parallel_out, m_data);

    // Reset mid left slot drops the partial sample
    sample_ready = 1'b1;
    step(4);
    cnt = 0;
    while (cur_p != 3 && cnt < 600) begin
      step(1); cnt++;
    end
    check_eq("mid_found", (cnt < 600), 1);
    step(1);
    rst = 1'b1;
    step(50);
    check_eq("mid_valid", sample_valid, 0);
    check_eq("mid_data", parallel_out, 0);
    rst = 1'b0;
    cnt = 0;
    do begin
      @(posedge clk); #1; cnt++;
    end while (!sample_valid && cnt < 300);
    check_eq("mid_latency", cnt, CLK_DIV * (1 + 2 * DATA_W));
    check_eq("mid_right", sample_right, 0);
    step(600);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
